// File: rtl/asyn_fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
package asyn_fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned ASIZE_DEF = 4;
    localparam int unsigned PTR_MAXW  = 32;

    // Callers zero-extend into PTR_MAXW and truncate the result, so any pointer width up to 32 works.
    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b = g;
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// First-word-fall-through output register with a valid/ready handshake and load strobe.
module fifo_out_reg
    import asyn_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             load,
    input  logic [DSIZE-1:0] din,
    input  logic             ready,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid
);

    // A load on the same edge as ready replaces the departing word, giving one word per cycle.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= din;
            dout_valid <= 1'b1;
        end else if (ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty flag, fill level
// and the output register that presents the head word.
module fifo_rd_ctrl
    import asyn_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0] rdata,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ASIZE:0]   rlevel
);

    localparam int unsigned PW = ASIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext_c;
    logic [PW-1:0] rgraynext_c;
    logic [PW-1:0] wbin_c;
    logic          pop_c;

    // Pull a word only when memory has one and the output slot is free or freeing.
    assign pop_c       = !rempty && (!dout_valid || dout_ready);
    assign rbinnext_c  = rbin + PW'(pop_c);
    assign rgraynext_c = PW'(bin2gray(PTR_MAXW'(rbinnext_c)));
    assign wbin_c      = PW'(gray2bin(PTR_MAXW'(rq2_wptr)));
    assign raddr       = rbin[ASIZE-1:0];

    // Full-width Gray compare makes empty correct across pointer wrap.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext_c;
            rptr   <= rgraynext_c;
            rempty <= (rgraynext_c == rq2_wptr);
            rlevel <= wbin_c - rbinnext_c;
        end
    end

    fifo_out_reg #(
        .DSIZE (DSIZE)
    ) u_out_reg (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .load       (pop_c),
        .din        (rdata),
        .ready      (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: models fifomem and the write side, scoreboards delivered words.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [4:0] consumed;
    logic [7:0] exp_q [$];
    int         n_checks;
    int         n_fail;

    fifo_rd_ctrl #(.DSIZE(8), .ASIZE(4)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rq2_wptr   (rq2_wptr),
        .rdata      (rdata),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rlevel     (rlevel)
    );

    assign rdata = mem[raddr];

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic write_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        wbin = wbin + 5'd1;
        rq2_wptr = to_gray(wbin);
        exp_q.push_back(d);
    endtask

    // Score any handshake completing on the coming edge, then advance one cycle.
    task automatic tick();
        if (rrst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(dout_valid), 32'd0);
            end else begin
                check("sb_data", 32'(dout), 32'(exp_q.pop_front()));
                consumed = consumed + 5'd1;
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        rq2_wptr = '0;
        dout_ready = 1'b0;
        wbin = '0;
        consumed = '0;
        exp_q.delete();
        tick();
        rrst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        do_reset();
        tick();

        // reset state
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_rlevel", 32'(rlevel), 32'd0);

        // single word latency
        dout_ready = 1'b1;
        write_word(8'hA5);
        tick();
        check("one_e1_rempty", 32'(rempty), 32'd0);
        check("one_e1_rlevel", 32'(rlevel), 32'd1);
        check("one_e1_valid", 32'(dout_valid), 32'd0);
        tick();
        check("one_e2_dout", 32'(dout), 32'hA5);
        check("one_e2_valid", 32'(dout_valid), 32'd1);
        check("one_e2_rptr", 32'(rptr), 32'h01);
        check("one_e2_rempty", 32'(rempty), 32'd1);
        tick();
        check("one_e3_valid", 32'(dout_valid), 32'd0);

        // backpressure then back-to-back drain
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        check("bp_wptr", 32'(rq2_wptr), 32'h02);
        tick();
        tick();
        tick();
        check("bp_dout", 32'(dout), 32'h11);
        check("bp_valid", 32'(dout_valid), 32'd1);
        check("bp_rptr", 32'(rptr), 32'h01);
        check("bp_rempty", 32'(rempty), 32'd0);
        check("bp_rlevel", 32'(rlevel), 32'd2);
        dout_ready = 1'b1;
        tick();
        check("b2b_dout1", 32'(dout), 32'h22);
        check("b2b_valid1", 32'(dout_valid), 32'd1);
        tick();
        check("b2b_dout2", 32'(dout), 32'h33);
        check("b2b_valid2", 32'(dout_valid), 32'd1);
        tick();
        check("b2b_valid3", 32'(dout_valid), 32'd0);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // full, then drain through the pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'(8'h40 + i));
        check("full_wptr", 32'(rq2_wptr), 32'h18);
        tick();
        check("full_rlevel", 32'(rlevel), 32'd16);
        check("full_rempty", 32'(rempty), 32'd0);
        tick();
        check("full_rlevel_after_load", 32'(rlevel), 32'd15);
        check("full_dout", 32'(dout), 32'h40);
        dout_ready = 1'b1;
        for (int i = 0; i < 40 && (dout_valid || !rempty); i++) tick();
        check("wrap_drained", 32'(dout_valid), 32'd0);
        check("wrap_rptr", 32'(rptr), 32'h18);
        check("wrap_raddr", 32'(raddr), 32'd0);
        check("wrap_rempty", 32'(rempty), 32'd1);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        write_word(8'h3C);
        tick();
        check("wrap17_rempty", 32'(rempty), 32'd0);
        tick();
        check("wrap17_rptr", 32'(rptr), 32'h19);
        check("wrap17_dout", 32'(dout), 32'h3C);
        tick();
        check("wrap17_valid", 32'(dout_valid), 32'd0);

        // random writes and random consumer stalls
        for (int c = 0; c < 400; c++) begin
            dout_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && 5'(wbin - consumed) < 5'd16)
                write_word(8'($urandom_range(0, 255)));
            tick();
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || dout_valid); i++) tick();
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);
        check("rand_valid", 32'(dout_valid), 32'd0);
        check("rand_rempty", 32'(rempty), 32'd1);
        check("rand_rlevel", 32'(rlevel), 32'd0);

        // reset while the consumer is stalled on a held word
        do_reset();
        write_word(8'h77);
        write_word(8'h88);
        tick();
        tick();
        tick();
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", 32'(dout), 32'h77);
        rrst_n = 1'b0;
        rq2_wptr = '0;
        wbin = '0;
        consumed = '0;
        exp_q.delete();
        tick();
        check("mrst_valid", 32'(dout_valid), 32'd0);
        check("mrst_rptr", 32'(rptr), 32'd0);
        check("mrst_raddr", 32'(raddr), 32'd0);
        check("mrst_rempty", 32'(rempty), 32'd1);
        check("mrst_rlevel", 32'(rlevel), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        rrst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
